// File: rtl/fpu_pkg.sv
// Shared FPU types and flag bit positions for the divider and its commit stage.
package fpu_pkg;

  // Bit positions inside an IEEE exception-flag vector.
  localparam int FLAG_NV = 4;  // invalid
  localparam int FLAG_DZ = 3;  // divide by zero
  localparam int FLAG_OF = 2;  // overflow
  localparam int FLAG_UF = 1;  // underflow
  localparam int FLAG_NX = 0;  // inexact

  typedef logic [4:0]  fflags_t;
  typedef logic [31:0] sp_word_t;

endpackage

// File: rtl/fpu_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter and synchronous flush.
// Push and pop requests are gated internally against full and empty.
module fpu_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_en = push & ~full & ~flush;
  assign pop_en  = pop & ~empty & ~flush;

  // Next pointer and occupancy; flush overrides any push or pop this cycle.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  // NOTE: the array is deliberately not reset; its contents are only observed behind a valid count.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sp_div_commit.sv
// Commit stage for the single-precision divider: queues results with flags and
// tags, retires them in order to writeback, and accumulates sticky fflags.
module sp_div_commit
  import fpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = 5,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  sp_word_t         in_result,
  input  fflags_t          in_flags,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output sp_word_t         out_result,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush,
  input  logic             fflags_clr,
  output fflags_t          fflags,
  output logic [CNT_W-1:0] count
);

  localparam int ENTRY_W = $bits(sp_word_t) + $bits(fflags_t) + TAG_W;

  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;
  fflags_t            head_flags;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_fire;
  logic               pop_fire;
  fflags_t            fflags_q, fflags_d;

  assign wr_entry = {in_result, in_flags, in_tag};

  fpu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_fire),
    .wdata (wr_entry),
    .pop   (pop_fire),
    .rdata (head_entry),
    .flush (flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // Handshake terms come only from registered occupancy, never from the other side.
  assign in_ready   = ~fifo_full;
  assign out_valid  = ~fifo_empty;
  assign push_fire  = in_valid & in_ready;
  assign pop_fire   = out_valid & out_ready;

  assign out_result = head_entry[TAG_W + $bits(fflags_t) +: $bits(sp_word_t)];
  assign head_flags = head_entry[TAG_W +: $bits(fflags_t)];
  assign out_tag    = head_entry[TAG_W-1:0];
  assign fflags     = fflags_q;

  // Sticky flags: clear applies first, then a non-flushed retire ORs in the head flags.
  always_comb begin
    fflags_d = fflags_clr ? '0 : fflags_q;
    if (pop_fire && !flush) fflags_d = fflags_d | head_flags;
  end

  // Sticky flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fflags_q <= '0;
    else     fflags_q <= fflags_d;
  end

endmodule

// File: tb/tb_sp_div_commit.sv
// Directed self-checking bench for sp_div_commit.
module tb_sp_div_commit;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic [4:0]       in_flags;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             flush;
  logic             fflags_clr;
  logic [4:0]       fflags;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  sp_div_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_flags   (in_flags),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .flush      (flush),
    .fflags_clr (fflags_clr),
    .fflags     (fflags),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [31:0] r, input logic [4:0] f,
                          input logic [TAG_W-1:0] t);
    in_valid  = v;
    in_result = r;
    in_flags  = f;
    in_tag    = t;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
    set_push(1'b0, '0, '0, '0);
    step();
    check("rst_count",     64'(count),     64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fflags",    64'(fflags),    64'd0);
    rst = 1'b0;

    // Single push and immediate retire.
    out_ready = 1'b1;
    set_push(1'b1, 32'h3F80_0000, 5'b00001, 5'd3);
    step();
    in_valid = 1'b0;
    check("single_out_valid",  64'(out_valid),  64'd1);
    check("single_out_tag",    64'(out_tag),    64'd3);
    check("single_out_result", 64'(out_result), 64'h3F80_0000);
    check("single_count",      64'(count),      64'd1);
    step();
    check("single_fflags", 64'(fflags), 64'b00001);
    check("single_count0", 64'(count),  64'd0);

    // Fill to full with writeback stalled.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_push(1'b1, 32'h100 + 32'(i), 5'b00000, TAG_W'(i));
      step();
    end
    check("full_count",    64'(count),    64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    set_push(1'b1, 32'h999, 5'b11111, 5'd9);
    step();
    in_valid = 1'b0;
    check("full_5th_count", 64'(count),   64'd4);
    check("full_head_tag",  64'(out_tag), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain_tag%0d", i),    64'(out_tag),    64'(i));
      check($sformatf("drain_result%0d", i), 64'(out_result), 64'h100 + 64'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_count",  64'(count),     64'd0);
    check("drain_valid",  64'(out_valid), 64'd0);
    check("drain_fflags", 64'(fflags),    64'b00001);

    // Backpressure stability, after a clear.
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    check("clr_alone0", 64'(fflags), 64'd0);
    set_push(1'b1, 32'hDEAD_BEEF, 5'b01000, 5'd7);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_result%0d", i), 64'(out_result), 64'hDEAD_BEEF);
      check($sformatf("bp_tag%0d", i),    64'(out_tag),    64'd7);
      check($sformatf("bp_fflags%0d", i), 64'(fflags),     64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_retire_fflags", 64'(fflags), 64'b01000);
    check("bp_retire_count",  64'(count),  64'd0);

    // Clear together with retire: clear first, then OR.
    out_ready = 1'b1;
    set_push(1'b1, 32'h4000_0000, 5'b10000, 5'd1);
    step();
    in_valid = 1'b0;
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    out_ready = 1'b0;
    check("clr_ret_a", 64'(fflags), 64'b10000);
    set_push(1'b1, 32'h4040_0000, 5'b00100, 5'd2);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    fflags_clr = 1'b1;
    step();
    out_ready = 1'b0;
    fflags_clr = 1'b0;
    check("clr_ret_b", 64'(fflags), 64'b00100);
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    check("clr_alone", 64'(fflags), 64'd0);

    // Flush with a handshaking head and a concurrent push.
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'h200 + 32'(i), 5'b00010, TAG_W'(10 + i));
      step();
    end
    check("pre_flush_count", 64'(count), 64'd3);
    out_ready = 1'b1;
    flush = 1'b1;
    set_push(1'b1, 32'h300, 5'b00010, 5'd20);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("flush_count",  64'(count),     64'd0);
    check("flush_valid",  64'(out_valid), 64'd0);
    check("flush_fflags", 64'(fflags),    64'd0);
    step();
    check("flush_count_hold", 64'(count), 64'd0);

    // Asynchronous reset mid-stream.
    out_ready = 1'b1;
    set_push(1'b1, 32'h500, 5'b00001, 5'd5);
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("pre_arst_fflags", 64'(fflags), 64'b00001);
    for (int i = 0; i < 2; i++) begin
      set_push(1'b1, 32'h600 + 32'(i), 5'b00000, TAG_W'(i));
      step();
    end
    in_valid = 1'b0;
    check("pre_arst_count", 64'(count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count",     64'(count),     64'd0);
    check("arst_fflags",    64'(fflags),    64'd0);
    check("arst_in_ready",  64'(in_ready),  64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    #1;
    rst = 1'b0;
    step();
    check("post_arst_count", 64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
